// File: rtl/psk_addr_gen_if.sv
// Symbol handshake between the symbol source and the PSK address generator.
//   sym_data  : symbol value (SYM_BITS wide, natural binary)
//   sym_valid : sym_data is valid (source -> generator)
//   sym_ready : one-entry symbol buffer can accept (generator -> source)
interface psk_addr_gen_if #(
    parameter int SYM_BITS = 1
);
    logic [SYM_BITS-1:0] sym_data;
    logic                sym_valid;
    logic                sym_ready;

    modport master (output sym_data, output sym_valid, input sym_ready);
    modport slave  (input sym_data, input sym_valid, output sym_ready);
endinterface

// File: rtl/psk_addr_gen.sv
// Carrier-table address generator for the PSK/DPSK modulator.
// Walks a 2^ADDR_W-entry sine ROM, applying a per-symbol phase offset
// (absolute or differential) at each symbol boundary.
//
// Ports:
//   i_clk          sample clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_en           run enable; low returns the FSM to IDLE
//   i_diff_mode    1 = differential (phase += offset), 0 = absolute
//   sym_if         symbol valid/ready handshake (slave side)
//   o_address      registered ROM address
//   o_sym_start    pulse on the first address of each symbol
//   o_underrun     pulse when a boundary is reached with an empty buffer
//   o_clk_DA       DAC clock (pass-through of i_clk)
//   o_blank_DA_n   low in IDLE/PRIME, high in RUN
//   o_sync_DA_n    constant high
//
// state | meaning
// IDLE  | counters, phase and address held at 0
// PRIME | waiting for the first buffered symbol
// RUN   | walking the table, phase updated at symbol boundaries
module psk_addr_gen #(
    parameter int ADDR_W         = 5,
    parameter int SYM_BITS       = 1,
    parameter int CYCLES_PER_SYM = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic              i_diff_mode,
    psk_addr_gen_if.slave     sym_if,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_sym_start,
    output logic              o_underrun,
    output logic              o_clk_DA,
    output logic              o_blank_DA_n,
    output logic              o_sync_DA_n
);
    localparam int PER_W = (CYCLES_PER_SYM > 1) ? $clog2(CYCLES_PER_SYM) : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(CYCLES_PER_SYM - 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_samp_cnt;
    logic [PER_W-1:0]    r_per_cnt;
    logic [ADDR_W-1:0]   r_phase;
    logic [ADDR_W-1:0]   r_address;
    logic                r_sym_start;
    logic                r_underrun;
    logic                r_buf_full;
    logic [SYM_BITS-1:0] r_buf_data;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_samp_nxt;
    logic [PER_W-1:0]    w_per_nxt;
    logic [ADDR_W-1:0]   w_phase_nxt;
    logic                w_start_nxt;
    logic                w_under_nxt;
    logic                w_consume;
    logic                w_boundary;
    logic                w_accept;
    logic [ADDR_W-1:0]   w_offset;

    assign w_boundary = (&r_samp_cnt) && (r_per_cnt == PER_LAST);
    // Symbol value scaled to a fraction of the carrier period.
    assign w_offset   = ADDR_W'(r_buf_data) << (ADDR_W - SYM_BITS);

    always_comb begin
        w_state_nxt = r_state;
        w_samp_nxt  = '0;
        w_per_nxt   = '0;
        w_phase_nxt = '0;
        w_start_nxt = 1'b0;
        w_under_nxt = 1'b0;
        w_consume   = 1'b0;
        if (!i_en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = PRIME;
                end
                PRIME: begin
                    // Reference phase is 0, so both modes load the offset directly.
                    if (r_buf_full) begin
                        w_consume   = 1'b1;
                        w_state_nxt = RUN;
                        w_phase_nxt = w_offset;
                        w_start_nxt = 1'b1;
                    end
                end
                RUN: begin
                    w_samp_nxt  = r_samp_cnt + 1'b1;
                    w_per_nxt   = r_per_cnt;
                    w_phase_nxt = r_phase;
                    if (w_boundary) begin
                        w_per_nxt   = '0;
                        w_start_nxt = 1'b1;
                        if (r_buf_full) begin
                            w_consume   = 1'b1;
                            w_phase_nxt = i_diff_mode ? (r_phase + w_offset) : w_offset;
                        end else begin
                            w_under_nxt = 1'b1;
                        end
                    end else if (&r_samp_cnt) begin
                        w_per_nxt = r_per_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Same-cycle accept/consume keeps the source streaming without a bubble.
    assign sym_if.sym_ready = !r_buf_full || w_consume;
    assign w_accept         = sym_if.sym_valid && sym_if.sym_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_samp_cnt  <= '0;
            r_per_cnt   <= '0;
            r_phase     <= '0;
            r_address   <= '0;
            r_sym_start <= 1'b0;
            r_underrun  <= 1'b0;
            r_buf_full  <= 1'b0;
            r_buf_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_samp_cnt  <= w_samp_nxt;
            r_per_cnt   <= w_per_nxt;
            r_phase     <= w_phase_nxt;
            r_address   <= w_samp_nxt + w_phase_nxt;
            r_sym_start <= w_start_nxt;
            r_underrun  <= w_under_nxt;
            if (w_accept) begin
                r_buf_full <= 1'b1;
                r_buf_data <= sym_if.sym_data;
            end else if (w_consume) begin
                r_buf_full <= 1'b0;
            end
        end
    end

    assign o_address    = r_address;
    assign o_sym_start  = r_sym_start;
    assign o_underrun   = r_underrun;
    assign o_clk_DA     = i_clk;
    assign o_blank_DA_n = (r_state == RUN);
    assign o_sync_DA_n  = 1'b1;
endmodule

// File: tb/tb_psk_addr_gen.sv
module tb_psk_addr_gen;
    localparam int ADDR_W  = 5;
    localparam int SYM_BITS = 2;
    localparam int CPS     = 2;
    localparam int DEPTH   = 32;
    localparam int SYM_LEN = CPS * DEPTH;
    localparam int STEP    = DEPTH / (1 << SYM_BITS);

    logic clk, rst, en, diff;
    logic [ADDR_W-1:0] o_address;
    logic o_sym_start, o_underrun, o_clk_DA, o_blank_DA_n, o_sync_DA_n;

    psk_addr_gen_if #(.SYM_BITS(SYM_BITS)) sif ();

    psk_addr_gen #(.ADDR_W(ADDR_W), .SYM_BITS(SYM_BITS), .CYCLES_PER_SYM(CPS)) dut (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_diff_mode(diff),
        .sym_if(sif),
        .o_address(o_address), .o_sym_start(o_sym_start), .o_underrun(o_underrun),
        .o_clk_DA(o_clk_DA), .o_blank_DA_n(o_blank_DA_n), .o_sync_DA_n(o_sync_DA_n));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 prime, 2 run; m_t is the sample index
    // inside the current symbol (0..SYM_LEN-1).
    int m_mode = 0, m_buf = 0, m_phase = 0, m_t = 0, m_addr = 0;
    bit m_full = 0, m_start = 0, m_und = 0, m_acc = 0;
    int cyc = 0;
    int lg_addr[$], lg_und[$], lg_cyc[$];

    function automatic bit m_consume();
        return en && m_full && (m_mode == 1 || (m_mode == 2 && m_t == SYM_LEN - 1));
    endfunction

    function automatic bit m_ready();
        return !m_full || m_consume();
    endfunction

    always @(posedge clk) begin
        bit cons;
        cyc++;
        if (rst) begin
            m_mode = 0; m_full = 0; m_buf = 0; m_phase = 0; m_t = 0;
            m_start = 0; m_und = 0; m_acc = 0;
        end else begin
            cons    = m_consume();
            m_acc   = sif.sym_valid && m_ready();
            m_start = 0;
            m_und   = 0;
            if (!en) begin
                m_mode = 0; m_t = 0; m_phase = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (m_full) begin
                    m_mode = 2; m_t = 0; m_phase = m_buf * STEP; m_start = 1;
                end
            end else begin
                if (m_t == SYM_LEN - 1) begin
                    m_t = 0; m_start = 1;
                    if (m_full) m_phase = diff ? (m_phase + m_buf * STEP) % DEPTH : m_buf * STEP;
                    else m_und = 1;
                end else begin
                    m_t++;
                end
            end
            if (cons) m_full = 0;
            if (m_acc) begin
                m_full = 1;
                m_buf  = int'(sif.sym_data);
            end
        end
        m_addr = (m_mode == 2) ? ((m_t % DEPTH) + m_phase) % DEPTH : 0;
        #1;
        check("address", int'(o_address), m_addr);
        check("sym_start", int'(o_sym_start), int'(m_start));
        check("underrun", int'(o_underrun), int'(m_und));
        check("blank_DA_n", int'(o_blank_DA_n), int'(m_mode == 2));
        check("sync_DA_n", int'(o_sync_DA_n), 1);
        check("clk_DA_hi", int'(o_clk_DA), int'(clk));
        if (!rst && o_sym_start) begin
            lg_addr.push_back(int'(o_address));
            lg_und.push_back(int'(o_underrun));
            lg_cyc.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            check("sym_ready", int'(sif.sym_ready), int'(m_ready()));
            check("clk_DA_lo", int'(o_clk_DA), int'(clk));
        end
    end

    // Symbol source: 0 = queued list, 1 = valid held high, 2 = random gaps.
    int src_mode = 0;
    int q[$];
    always @(negedge clk) begin
        if (m_acc && src_mode == 0 && q.size() > 0) void'(q.pop_front());
        case (src_mode)
            0: begin
                sif.sym_valid = (q.size() > 0);
                sif.sym_data  = (q.size() > 0) ? SYM_BITS'(q[0]) : '0;
            end
            1: begin
                sif.sym_valid = 1'b1;
                sif.sym_data  = SYM_BITS'($urandom_range(0, 3));
            end
            default: begin
                sif.sym_valid = ($urandom_range(0, 2) == 0);
                sif.sym_data  = SYM_BITS'($urandom_range(0, 3));
            end
        endcase
    end

    task automatic clear_log();
        lg_addr.delete(); lg_und.delete(); lg_cyc.delete();
    endtask

    task automatic restart(input bit d);
        @(negedge clk); en = 1'b0;
        repeat (2) @(negedge clk);
        clear_log();
        diff = d;
    endtask

    task automatic check_starts(input string name, input int exp_addr[], input int exp_und[]);
        check({name, "_nstarts"}, int'(lg_addr.size() >= exp_addr.size()), 1);
        if (lg_addr.size() >= exp_addr.size()) begin
            foreach (exp_addr[i]) begin
                check($sformatf("%s_addr%0d", name, i), lg_addr[i], exp_addr[i]);
                check($sformatf("%s_und%0d", name, i), lg_und[i], exp_und[i]);
                if (i > 0) check($sformatf("%s_len%0d", name, i), lg_cyc[i] - lg_cyc[i-1], SYM_LEN);
            end
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1; en = 1'b0; diff = 1'b0;
        sif.sym_valid = 1'b0; sif.sym_data = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_address", int'(o_address), 0);
        check("rst_sym_ready", int'(sif.sym_ready), 1);
        check("rst_sym_start", int'(o_sym_start), 0);
        check("rst_underrun", int'(o_underrun), 0);
        check("rst_blank", int'(o_blank_DA_n), 0);
        check("rst_sync", int'(o_sync_DA_n), 1);
        @(negedge clk); rst = 1'b0;

        // Absolute: 0,1,2,3 then an underrun holding the last phase.
        q = '{0, 1, 2, 3};
        clear_log();
        en = 1'b1;
        repeat (5 * SYM_LEN + 10) @(negedge clk);
        check_starts("abs", '{0, 8, 16, 24, 24}, '{0, 0, 0, 0, 1});

        // Differential: 2,2,0 -> phases 16, 0, 0.
        restart(1'b1);
        q = '{2, 2, 0};
        en = 1'b1;
        repeat (3 * SYM_LEN + 10) @(negedge clk);
        check_starts("diff", '{16, 0, 0}, '{0, 0, 0});

        // Underrun then late symbol 0.
        restart(1'b0);
        q = '{2};
        en = 1'b1;
        repeat (70) @(negedge clk);
        q.push_back(0);
        repeat (80) @(negedge clk);
        check_starts("undr", '{16, 16, 0}, '{0, 1, 0});

        // Back-pressure: valid held high, differential.
        restart(1'b1);
        src_mode = 1;
        en = 1'b1;
        repeat (6 * SYM_LEN) @(negedge clk);

        // en dropped at sample 10 of a symbol.
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #2;
            seen = o_sym_start;
        end
        check("en_wait_start", int'(seen), 1);
        repeat (10) @(negedge clk);
        en = 1'b0;
        @(posedge clk); #2;
        check("en_drop_addr", int'(o_address), 0);
        check("en_drop_blank", int'(o_blank_DA_n), 0);
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (150) @(negedge clk);

        // Randomized traffic, mode and enable.
        src_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            diff = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
        end

        // Asynchronous reset mid-symbol.
        src_mode = 0;
        q = '{1};
        en = 1'b1;
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_address", int'(o_address), 0);
        check("arst_sym_ready", int'(sif.sym_ready), 1);
        check("arst_sym_start", int'(o_sym_start), 0);
        check("arst_underrun", int'(o_underrun), 0);
        check("arst_blank", int'(o_blank_DA_n), 0);
        @(negedge clk); rst = 1'b0;
        q = '{3};
        repeat (100) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
